sram_1rw1r_param: RTL and testbench

- Parametrised, synthesizable successor to the fixed 32x512 1RW+1R macro model.
- Storage is a generic array; width and depth are configurable.
- Adds configurable read pipeline depth and a post-reset zero-initialisation sweep.
- Adds same-address write-to-read forwarding on port 1 and collision reporting.
- Used as the on-chip scratch/instruction RAM behind the bus adapters, and as a drop-in for the hard macro in simulation and FPGA builds.

---
 rtl/sram_pkg.sv | 33 +++
 rtl/sram_1rw1r_param_if.sv | 36 +++
 rtl/sram_rd_pipe.sv | 56 +++++
 rtl/sram_1rw1r_param.sv | 133 +++++++++++++
 tb/tb_sram_1rw1r_param.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared types and helpers for the parametrised 1RW+1R SRAM
package sram_pkg;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } sram_state_e;

    // Widest word the byte-merge helper handles; narrower words are zero-extended.
    localparam int SRAM_MAX_DW = 1024;
    localparam int SRAM_MAX_WM = SRAM_MAX_DW / 8;

    function automatic int num_wmasks(input int data_width);
        return data_width / 8;
    endfunction

    // Byte i of the result is new_word's byte when mask[i] is set, else old_word's.
    function automatic logic [SRAM_MAX_DW-1:0] merge_bytes(
        input logic [SRAM_MAX_DW-1:0] old_word,
        input logic [SRAM_MAX_DW-1:0] new_word,
        input logic [SRAM_MAX_WM-1:0] mask
    );
        logic [SRAM_MAX_DW-1:0] res;
        res = old_word;
        for (int i = 0; i < SRAM_MAX_WM; i++) begin
            if (mask[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sram_1rw1r_param_if.sv
// rtl/sram_1rw1r_param_if.sv - request/response bundle for the 1RW+1R SRAM
interface sram_1rw1r_param_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9
);
    localparam int NUM_WMASKS = sram_pkg::num_wmasks(DATA_WIDTH);

    logic                  init_done_o;
    logic                  p0_req_i;
    logic                  p0_we_i;
    logic [NUM_WMASKS-1:0] p0_wmask_i;
    logic [ADDR_WIDTH-1:0] p0_addr_i;
    logic [DATA_WIDTH-1:0] p0_wdata_i;
    logic [DATA_WIDTH-1:0] p0_rdata_o;
    logic                  p0_rvalid_o;
    logic                  p1_req_i;
    logic [ADDR_WIDTH-1:0] p1_addr_i;
    logic [DATA_WIDTH-1:0] p1_rdata_o;
    logic                  p1_rvalid_o;
    logic                  collision_o;

    modport master (
        output p0_req_i, p0_we_i, p0_wmask_i, p0_addr_i, p0_wdata_i,
        output p1_req_i, p1_addr_i,
        input  init_done_o, p0_rdata_o, p0_rvalid_o,
        input  p1_rdata_o, p1_rvalid_o, collision_o
    );

    modport slave (
        input  p0_req_i, p0_we_i, p0_wmask_i, p0_addr_i, p0_wdata_i,
        input  p1_req_i, p1_addr_i,
        output init_done_o, p0_rdata_o, p0_rvalid_o,
        output p1_rdata_o, p1_rvalid_o, collision_o
    );

endinterface

// File: rtl/sram_rd_pipe.sv
// rtl/sram_rd_pipe.sv - 1- or 2-stage registered read-response pipeline
module sram_rd_pipe #(
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o
);

    logic                  s1_valid_q;
    logic [DATA_WIDTH-1:0] s1_data_q;
    logic [DATA_WIDTH-1:0] s1_data_d;

    assign s1_data_d = valid_i ? data_i : s1_data_q;

    // First stage captures the word sampled at the accepting edge and holds it between reads
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
        end else begin
            s1_valid_q <= valid_i;
            s1_data_q  <= s1_data_d;
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic                  s2_valid_q;
        logic [DATA_WIDTH-1:0] s2_data_q;
        logic [DATA_WIDTH-1:0] s2_data_d;

        assign s2_data_d = s1_valid_q ? s1_data_q : s2_data_q;

        // Extra output stage; same hold-when-idle behaviour as the first
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                s2_valid_q <= 1'b0;
                s2_data_q  <= '0;
            end else begin
                s2_valid_q <= s1_valid_q;
                s2_data_q  <= s2_data_d;
            end
        end

        assign valid_o = s2_valid_q;
        assign data_o  = s2_data_q;
    end else begin : g_lat1
        assign valid_o = s1_valid_q;
        assign data_o  = s1_data_q;
    end

endmodule

// File: rtl/sram_1rw1r_param.sv
// rtl/sram_1rw1r_param.sv - parametrised 1RW+1R SRAM with init sweep, bypass and collision flag
module sram_1rw1r_param
    import sram_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 9,
    parameter int READ_LATENCY = 1,
    parameter int INIT_ZERO    = 1,
    parameter int BYPASS       = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    sram_1rw1r_param_if.slave  bus
);

    localparam int NUM_WMASKS = num_wmasks(DATA_WIDTH);
    localparam int DEPTH      = 1 << ADDR_WIDTH;

    if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH > SRAM_MAX_DW) begin : g_bad_width
        $error("sram_1rw1r_param: DATA_WIDTH must be a multiple of 8 and at most SRAM_MAX_DW");
    end
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("sram_1rw1r_param: READ_LATENCY must be 1 or 2");
    end

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    sram_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
    logic                  done_q, done_d;

    // Sweep sequencing: walk every address once, then hand over to normal operation
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        if (state_q == ST_INIT) begin
            init_cnt_d = init_cnt_q + 1'b1;
            if (init_cnt_q == '1) begin
                state_d = ST_RUN;
            end
        end
        done_d = (state_d == ST_RUN);
    end

    // Control state; reset always restarts the sweep from address 0
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= (INIT_ZERO != 0) ? ST_INIT : ST_RUN;
            init_cnt_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            done_q     <= done_d;
        end
    end

    assign bus.init_done_o = done_q;

    logic                  wr_en, p0_rd_en, p1_rd_en, coll;
    logic [NUM_WMASKS-1:0] wmask;
    logic [DATA_WIDTH-1:0] p0_old, p1_old, wr_word, p1_rd_word;

    assign wr_en    = done_q & bus.p0_req_i & bus.p0_we_i;
    assign p0_rd_en = done_q & bus.p0_req_i & ~bus.p0_we_i;
    assign p1_rd_en = done_q & bus.p1_req_i;
    assign coll     = wr_en & p1_rd_en & (bus.p0_addr_i == bus.p1_addr_i);

    assign wmask  = bus.p0_wmask_i;
    assign p0_old = mem_q[bus.p0_addr_i];
    assign p1_old = mem_q[bus.p1_addr_i];

    // The same merged word feeds the array write and the port-1 forward path
    assign wr_word = DATA_WIDTH'(merge_bytes(SRAM_MAX_DW'(p0_old),
                                             SRAM_MAX_DW'(bus.p0_wdata_i),
                                             SRAM_MAX_WM'(wmask)));

    assign p1_rd_word = (coll && (BYPASS != 0)) ? wr_word : p1_old;

    // Storage: zero sweep while initialising, masked write afterwards; reset leaves contents alone
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (state_q == ST_INIT) begin
                mem_q[init_cnt_q] <= '0;
            end else if (wr_en) begin
                mem_q[bus.p0_addr_i] <= wr_word;
            end
        end
    end

    sram_rd_pipe #(
        .DATA_WIDTH   (DATA_WIDTH),
        .READ_LATENCY (READ_LATENCY)
    ) u_p0_pipe (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (p0_rd_en),
        .data_i  (p0_old),
        .valid_o (bus.p0_rvalid_o),
        .data_o  (bus.p0_rdata_o)
    );

    sram_rd_pipe #(
        .DATA_WIDTH   (DATA_WIDTH),
        .READ_LATENCY (READ_LATENCY)
    ) u_p1_pipe (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (p1_rd_en),
        .data_i  (p1_rd_word),
        .valid_o (bus.p1_rvalid_o),
        .data_o  (bus.p1_rdata_o)
    );

    logic       coll_valid;
    logic [0:0] coll_data;

    // Collision flag travels through an identical pipe so it lines up with p1_rvalid_o
    sram_rd_pipe #(
        .DATA_WIDTH   (1),
        .READ_LATENCY (READ_LATENCY)
    ) u_coll_pipe (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (coll),
        .data_i  (coll),
        .valid_o (coll_valid),
        .data_o  (coll_data)
    );

    assign bus.collision_o = coll_valid & coll_data[0];

endmodule

// File: tb/tb_sram_1rw1r_param.sv
// tb/tb_sram_1rw1r_param.sv - scoreboard bench for two SRAM configurations
module tb_sram_1rw1r_param;

    localparam int DW    = 32;
    localparam int AW    = 9;
    localparam int DEPTH = 512;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit mon_on  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    sram_1rw1r_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ia ();
    sram_1rw1r_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ib ();

    assign ib.p0_req_i   = ia.p0_req_i;
    assign ib.p0_we_i    = ia.p0_we_i;
    assign ib.p0_wmask_i = ia.p0_wmask_i;
    assign ib.p0_addr_i  = ia.p0_addr_i;
    assign ib.p0_wdata_i = ia.p0_wdata_i;
    assign ib.p1_req_i   = ia.p1_req_i;
    assign ib.p1_addr_i  = ia.p1_addr_i;

    // A: latency 1 with forwarding; B: latency 2 without forwarding
    sram_1rw1r_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1),
                       .INIT_ZERO(1), .BYPASS(1)) dut_a (
        .clk_i (clk), .rst_i (rst), .bus (ia.slave));

    sram_1rw1r_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(2),
                       .INIT_ZERO(1), .BYPASS(0)) dut_b (
        .clk_i (clk), .rst_i (rst), .bus (ib.slave));

    typedef struct {
        logic [31:0] data;
        int          cyc;
        bit          coll;
    } exp_t;

    // Queues: 0 = A.p0, 1 = A.p1, 2 = B.p0, 3 = B.p1
    exp_t        q [4][$];
    logic [31:0] model [DEPTH];
    logic [31:0] last  [4];
    string       nm    [4] = '{"A.p0", "A.p1", "B.p0", "B.p1"};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Monitor: pops the oldest expectation whenever a port presents rvalid
    always @(negedge clk) begin
        logic        rv [4];
        logic [31:0] rd [4];
        logic        cl [4];
        exp_t        e;
        rv = '{ia.p0_rvalid_o, ia.p1_rvalid_o, ib.p0_rvalid_o, ib.p1_rvalid_o};
        rd = '{ia.p0_rdata_o, ia.p1_rdata_o, ib.p0_rdata_o, ib.p1_rdata_o};
        cl = '{1'b0, ia.collision_o, 1'b0, ib.collision_o};
        for (int k = 0; k < 4; k++) begin
            if (q[k].size() > 0 && q[k][0].cyc < cyc) begin
                e = q[k].pop_front();
                n_tests++; n_fail++;
                $display("FAIL %s missing response: got nothing expected %h at cycle %0d", nm[k], e.data, e.cyc);
            end
            if (rv[k] === 1'b1) begin
                if (q[k].size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL %s unexpected rvalid: got data %h expected no response (cycle %0d)", nm[k], rd[k], cyc);
                end else begin
                    e = q[k].pop_front();
                    chk({nm[k], " data"}, rd[k], e.data);
                    chk({nm[k], " cycle"}, cyc, e.cyc);
                    if (k % 2 == 1) chk1({nm[k], " collision"}, cl[k], e.coll);
                end
                last[k] = rd[k];
            end else if (mon_on) begin
                chk({nm[k], " rdata hold"}, rd[k], last[k]);
                if (k % 2 == 1 && cl[k] !== 1'b0) begin
                    n_tests++; n_fail++;
                    $display("FAIL %s stray collision: got %b expected 0 (cycle %0d)", nm[k], cl[k], cyc);
                end
            end
        end
    end

    task automatic rand_inputs();
        ia.p0_req_i   = 1'($urandom);
        ia.p0_we_i    = 1'($urandom);
        ia.p0_wmask_i = 4'($urandom);
        ia.p0_addr_i  = 9'($urandom);
        ia.p0_wdata_i = $urandom;
        ia.p1_req_i   = 1'($urandom);
        ia.p1_addr_i  = 9'($urandom);
    endtask

    // One accepted cycle: drive, predict from the model, then advance past the accepting edge
    task automatic op(input bit r0, input bit w0, input logic [3:0] m, input int a0_i,
                      input logic [31:0] wd, input bit r1, input int a1_i);
        exp_t        e;
        logic [31:0] merged;
        logic [8:0]  a0, a1;
        bit          c;
        a0 = 9'(a0_i);
        a1 = 9'(a1_i);
        ia.p0_req_i = r0; ia.p0_we_i = w0; ia.p0_wmask_i = m;
        ia.p0_addr_i = a0; ia.p0_wdata_i = wd;
        ia.p1_req_i = r1; ia.p1_addr_i = a1;
        merged = model[a0];
        for (int i = 0; i < 4; i++) if (m[i]) merged[8*i +: 8] = wd[8*i +: 8];
        if (r0 && !w0) begin
            e.data = model[a0]; e.coll = 1'b0;
            e.cyc = cyc + 1; q[0].push_back(e);
            e.cyc = cyc + 2; q[2].push_back(e);
        end
        if (r1) begin
            c = r0 && w0 && (a0 == a1);
            e.coll = c;
            e.data = c ? merged : model[a1]; e.cyc = cyc + 1; q[1].push_back(e);
            e.data = model[a1];              e.cyc = cyc + 2; q[3].push_back(e);
        end
        if (r0 && w0) model[a0] = merged;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        ia.p0_req_i = 1'b0; ia.p1_req_i = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic assert_reset();
        ia.p0_req_i = 1'b0; ia.p1_req_i = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin q[k].delete(); last[k] = '0; end
        mon_on = 1'b1;
        chk1("reset A p0_rvalid", ia.p0_rvalid_o, 1'b0);
        chk1("reset A p1_rvalid", ia.p1_rvalid_o, 1'b0);
        chk1("reset B p0_rvalid", ib.p0_rvalid_o, 1'b0);
        chk1("reset B p1_rvalid", ib.p1_rvalid_o, 1'b0);
        chk1("reset A collision", ia.collision_o, 1'b0);
        chk1("reset A init_done", ia.init_done_o, 1'b0);
        chk1("reset B init_done", ib.init_done_o, 1'b0);
        @(posedge clk); #1;
    endtask

    // Release reset and count edges until init_done; optionally throw ignored requests meanwhile
    task automatic release_and_init(input bit noisy);
        int rel;
        bit seen;
        rst = 1'b0;
        rel = cyc;
        seen = 1'b0;
        for (int k = 0; k < 2000 && !seen; k++) begin
            @(posedge clk); #1;
            if (ia.init_done_o === 1'b1) begin
                seen = 1'b1;
                ia.p0_req_i = 1'b0; ia.p1_req_i = 1'b0;
                chk("A init latency", cyc - rel, DEPTH);
                chk1("B init_done", ib.init_done_o, 1'b1);
            end else if (noisy) begin
                rand_inputs();
            end
        end
        if (!seen) begin
            n_tests++; n_fail++;
            $display("FAIL init timeout: got init_done=0 expected 1 within 2000 cycles");
        end
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, a1;
        ia.p0_req_i = 1'b0; ia.p0_we_i = 1'b0; ia.p0_wmask_i = '0;
        ia.p0_addr_i = '0; ia.p0_wdata_i = '0; ia.p1_req_i = 1'b0; ia.p1_addr_i = '0;
        for (int k = 0; k < 4; k++) last[k] = '0;

        @(posedge clk); #1;
        assert_reset();
        release_and_init(1'b1);

        op(1'b0, 1'b0, 4'h0, 0, 32'h0, 1'b1, 9'h1FF);
        op(1'b1, 1'b1, 4'hF, 5, 32'hDEADBEEF, 1'b0, 0);
        op(1'b0, 1'b0, 4'h0, 0, 32'h0, 1'b1, 5);
        op(1'b1, 1'b0, 4'h0, 5, 32'h0, 1'b0, 0);
        op(1'b1, 1'b1, 4'b0101, 5, 32'h11223344, 1'b0, 0);
        op(1'b1, 1'b0, 4'h0, 5, 32'h0, 1'b1, 5);
        idle(2);
        op(1'b1, 1'b1, 4'hF, 7, 32'hA5A5A5A5, 1'b1, 7);
        op(1'b1, 1'b0, 4'h0, 7, 32'h0, 1'b1, 7);
        for (int i = 1; i <= 3; i++) op(1'b1, 1'b1, 4'hF, i, $urandom, 1'b0, 0);
        for (int i = 1; i <= 3; i++) op(1'b0, 1'b0, 4'h0, 0, 32'h0, 1'b1, i);
        op(1'b1, 1'b1, 4'hF, 0, 32'h01020304, 1'b1, 9'h1FF);
        op(1'b1, 1'b1, 4'hF, 9'h1FF, 32'hCAFEF00D, 1'b1, 0);
        op(1'b1, 1'b1, 4'h0, 9'h1FF, 32'h12345678, 1'b1, 9'h1FF);
        op(1'b1, 1'b0, 4'h0, 9'h1FF, 32'h0, 1'b1, 9'h1FF);
        idle(3);

        for (int n = 0; n < 600; n++) begin
            a0 = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : 511) : $urandom_range(0, 15);
            a1 = ($urandom_range(0, 2) == 0) ? a0 : $urandom_range(0, 15);
            op($urandom_range(0, 3) != 0, 1'($urandom), 4'($urandom), a0, $urandom,
               $urandom_range(0, 3) != 0, a1);
            if ($urandom_range(0, 9) == 0) idle(1);
        end
        idle(4);

        assert_reset();
        rst = 1'b0;
        repeat (100) begin @(posedge clk); #1; rand_inputs(); end
        assert_reset();
        release_and_init(1'b0);
        op(1'b1, 1'b0, 4'h0, 5, 32'h0, 1'b1, 7);
        op(1'b1, 1'b0, 4'h0, 9'h1FF, 32'h0, 1'b1, 2);
        idle(2);

        op(1'b1, 1'b1, 4'hF, 9, 32'h5A5A0FF0, 1'b0, 0);
        op(1'b1, 1'b0, 4'h0, 9, 32'h0, 1'b1, 9);
        assert_reset();
        release_and_init(1'b0);
        op(1'b1, 1'b0, 4'h0, 9, 32'h0, 1'b1, 9);
        idle(4);

        chk("scoreboard drained", q[0].size() + q[1].size() + q[2].size() + q[3].size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
